tdc_hw_stats: RTL and testbench

// - Downstream consumer of the TDC thermometer-code popcount.
// - Accumulates 2**LOG_WIN valid hamming-weight samples into a window and computes sum, min and max.
// - Streams the window result as bytes over a valid/ready handshake, so it fits the 8-bit pin budget.
// - Sits between tdc_top (hw/val_out) and the chip-level output mux; clk is the TDC capture clock.

---
 rtl/tdc_pkg.sv | 22 ++
 rtl/tdc_byte_serializer.sv | 56 +++++
 rtl/tdc_hw_stats.sv | 130 +++++++++++++
 tb/tb_tdc_hw_stats.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC hamming-weight statistics block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } stats_state_t;

  // Width of a hamming weight able to hold 0..n inclusive.
  function automatic int hw_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Bytes needed to carry a full-window sum that can never overflow.
  function automatic int sum_bytes(input int n, input int log_win);
    return (hw_w(n) + log_win + 7) / 8;
  endfunction

endpackage

// File: rtl/tdc_byte_serializer.sv
// Parallel-load shadow register streamed out one byte at a time, index 0 first.
// Latency: load -> out_valid high on the next cycle with byte 0 already registered.
// Backpressure: out_byte/out_valid hold while out_ready is low; advance on valid&&ready.
module tdc_byte_serializer #(
  parameter  int NBYTES = 4,
  localparam int IDX_W  = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [NBYTES*8-1:0]   load_dat,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  output logic                  last_acc
);

  logic [7:0]       shadow [NBYTES];
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             accept;

  assign accept   = out_valid && out_ready;
  assign last_acc = accept && (byte_idx == IDX_W'(NBYTES - 1));
  assign nxt_idx  = byte_idx + 1'b1;

  // Shadow capture at window close, then byte-by-byte walk gated by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBYTES; i++) shadow[i] <= '0;
      byte_idx  <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NBYTES; i++) shadow[i] <= '0;
      byte_idx  <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < NBYTES; i++) shadow[i] <= load_dat[i*8 +: 8];
      byte_idx  <= '0;
      out_byte  <= load_dat[7:0];
      out_valid <= 1'b1;
    end else if (accept) begin
      if (last_acc) begin
        byte_idx  <= '0;
        out_valid <= 1'b0;
      end else begin
        byte_idx <= nxt_idx;
        out_byte <= shadow[nxt_idx];
      end
    end
  end

endmodule

// File: rtl/tdc_hw_stats.sv
// Windowed sum/min/max of TDC hamming weights, streamed out as bytes (sum LSB first, min, max).
// Latency: last sample of a window -> first result byte valid exactly 1 cycle later.
// Backpressure: out_ready low stalls the byte stream; samples outside ACCUM are dropped and flagged.
module tdc_hw_stats
  import tdc_pkg::*;
#(
  parameter  int N       = 64,
  parameter  int LOG_WIN = 8,
  localparam int HW_W    = hw_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [HW_W-1:0] hw,
  input  logic            hw_valid,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            dropped
);

  localparam int SUM_W  = HW_W + LOG_WIN;
  localparam int SUM_B  = sum_bytes(N, LOG_WIN);
  localparam int NBYTES = SUM_B + 2;
  localparam logic [LOG_WIN-1:0] CNT_LAST = '1;

  stats_state_t         state, state_nxt;
  logic [LOG_WIN-1:0]   cnt;
  logic [SUM_W-1:0]     sum, sum_nxt;
  logic [HW_W-1:0]      min_q, max_q, min_nxt, max_nxt;
  logic                 acc_init, acc_en, win_close, ser_clear, last_acc;
  logic [NBYTES*8-1:0]  load_dat;

  // Running statistics with the current sample folded in.
  always_comb begin
    sum_nxt = sum + SUM_W'(hw);
    min_nxt = (hw < min_q) ? hw : min_q;
    max_nxt = (hw > max_q) ? hw : max_q;
  end

  // Result bytes as the serializer expects them: padded sum, then min, then max.
  assign load_dat = {8'(max_nxt), 8'(min_nxt), (SUM_B*8)'(sum_nxt)};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode; abort overrides everything.
  always_comb begin
    state_nxt = state;
    acc_init  = 1'b0;
    acc_en    = 1'b0;
    win_close = 1'b0;
    ser_clear = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      ser_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = ACCUM;
            acc_init  = 1'b1;
          end
        end
        ACCUM: begin
          if (hw_valid) begin
            acc_en = 1'b1;
            if (cnt == CNT_LAST) begin
              win_close = 1'b1;
              state_nxt = DUMP;
            end
          end
        end
        DUMP: begin
          if (last_acc) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Accumulators: cleared on arm/abort, updated per accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sum   <= '0;
      min_q <= '1;
      max_q <= '0;
    end else if (abort || acc_init) begin
      cnt   <= '0;
      sum   <= '0;
      min_q <= '1;
      max_q <= '0;
    end else if (acc_en) begin
      cnt   <= cnt + 1'b1;
      sum   <= sum_nxt;
      min_q <= min_nxt;
      max_q <= max_nxt;
    end
  end

  // Sticky drop flag: set by any sample outside ACCUM, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              dropped <= 1'b0;
    else if (hw_valid && state != ACCUM)  dropped <= 1'b1;
    else if (acc_init)                    dropped <= 1'b0;
  end

  assign busy = (state != IDLE);

  tdc_byte_serializer #(
    .NBYTES (NBYTES)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (ser_clear),
    .load      (win_close),
    .load_dat  (load_dat),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .last_acc  (last_acc)
  );

endmodule

// File: tb/tb_tdc_hw_stats.sv
// Scoreboard bench for tdc_hw_stats: drivers push expected bytes, a monitor pops on accept.
// Latency: n/a.
// Backpressure: out_ready driven always-high, toggling or random by mode.
`timescale 1ns/1ps
module tb_tdc_hw_stats;

  localparam int N       = 64;
  localparam int LOG_WIN = 2;
  localparam int WIN     = 4;
  localparam int HW_W    = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [HW_W-1:0] hw = '0;
  logic            hw_valid = 1'b0;
  logic [7:0]      out_byte;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;
  logic            dropped;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int win_q[$];
  int rdy_mode = 0;
  bit mon_en = 1'b1;
  bit held_vld = 1'b0;
  int held_byte = 0;
  int exp_b;

  always #5 clk = ~clk;

  tdc_hw_stats #(.N(N), .LOG_WIN(LOG_WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .hw        (hw),
    .hw_valid  (hw_valid),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dropped   (dropped)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer readiness pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compare every accepted byte, and check stability while stalled.
  always @(negedge clk) begin
    if (!mon_en) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_byte", int'(out_byte), held_byte);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", int'(out_valid), 0);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte", int'(out_byte), exp_b);
        end
      end
      held_vld  = out_valid && !out_ready;
      held_byte = int'(out_byte);
    end
  end

  // Reference: a closed window yields sum (2 bytes LSB first), min, max.
  task automatic model_close();
    int s  = 0;
    int mn = 1000;
    int mx = -1;
    foreach (win_q[i]) begin
      s += win_q[i];
      if (win_q[i] < mn) mn = win_q[i];
      if (win_q[i] > mx) mx = win_q[i];
    end
    exp_q.push_back(s % 256);
    exp_q.push_back(s / 256);
    exp_q.push_back(mn);
    exp_q.push_back(mx);
    win_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_sample(input int v, input int gap);
    hw_valid = 1'b0;
    repeat (gap) step();
    hw       = HW_W'(v);
    hw_valid = 1'b1;
    win_q.push_back(v);
    if (win_q.size() == WIN) model_close();
    step();
    hw_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin
      step();
      k++;
    end
    check("drain_left", exp_q.size(), 0);
    check("busy_after", int'(busy), 0);
    check("valid_after", int'(out_valid), 0);
  endtask

  // Called right after the last sample's capture edge.
  task automatic finish_window();
    @(negedge clk);
    check("latency_valid", int'(out_valid), 1);
    check("busy_dump", int'(busy), 1);
    step();
    drain();
  endtask

  task automatic run_window(input int vals[WIN], input int maxgap);
    do_start();
    for (int i = 0; i < WIN; i++)
      send_sample(vals[i], (i == 0) ? 0 : int'($urandom_range(0, maxgap)));
    finish_window();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[WIN];

    // Reset values while rst is held.
    #3;
    check("rst_out_byte", int'(out_byte), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(dropped), 0);
    #9 rst = 1'b0;
    step();

    // Basic window, consumer always ready.
    rdy_mode = 0;
    run_window('{10, 20, 5, 33}, 0);

    // Same window under a toggling consumer.
    rdy_mode = 1;
    run_window('{10, 20, 5, 33}, 0);
    rdy_mode = 0;

    // Full-scale samples with gaps: 4 samples over 9 cycles.
    do_start();
    send_sample(64, 0);
    send_sample(64, 2);
    send_sample(64, 1);
    send_sample(64, 2);
    finish_window();

    // Abort partway, then a clean window with an ignored mid-window start.
    do_start();
    send_sample(7, 0);
    send_sample(9, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    win_q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(out_valid), 0);
    do_start();
    send_sample(1, 0);
    send_sample(1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_busy", int'(busy), 1);
    send_sample(1, 0);
    send_sample(1, 0);
    finish_window();
    check("abort_dropped", int'(dropped), 0);

    // Samples during DUMP and IDLE set the sticky drop flag.
    do_start();
    for (int i = 0; i < WIN; i++) send_sample(i + 3, 0);
    hw       = HW_W'(3);
    hw_valid = 1'b1;
    step();
    hw_valid = 1'b0;
    drain();
    check("drop_dump", int'(dropped), 1);
    hw_valid = 1'b1;
    step();
    hw_valid = 1'b0;
    check("drop_idle", int'(dropped), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("drop_after_abort", int'(dropped), 1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", int'(busy), 0);
    check("drop_kept_on_abort_start", int'(dropped), 1);
    do_start();
    check("drop_cleared_start", int'(dropped), 0);
    for (int i = 0; i < WIN; i++) send_sample(60 - i, 0);
    finish_window();
    check("drop_clean", int'(dropped), 0);

    // Reset mid-DUMP, asserted away from the clock edge.
    do_start();
    for (int i = 0; i < WIN; i++) send_sample(i * 11, 0);
    @(negedge clk);
    check("pre_rst_valid", int'(out_valid), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    exp_q.delete();
    win_q.delete();
    #4 rst = 1'b0;
    mon_en = 1'b1;
    step();
    run_window('{2, 50, 0, 17}, 1);

    // Randomized windows against a random consumer.
    rdy_mode = 2;
    for (int w = 0; w < 20; w++) begin
      for (int i = 0; i < WIN; i++) vals[i] = int'($urandom_range(0, N));
      run_window(vals, 3);
    end
    rdy_mode = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
